// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: default widths and pipeline stage indices.
package hazard_scoreboard_pkg;

  localparam int unsigned REG_ADDR_LEN_DEF = 5;
  localparam int unsigned DEPTH_DEF        = 3;
  localparam int unsigned CNT_LEN_DEF      = 16;

  localparam int unsigned STAGE_EXE = 0;
  localparam int unsigned STAGE_MEM = 1;
  localparam int unsigned STAGE_WB  = 2;

endpackage

// File: rtl/hazard_scoreboard_sb_match.sv
// Per-entry comparator: flags a read of this entry's destination by the instruction in ID.
module sb_match #(
  parameter int unsigned REG_ADDR_LEN = 5
) (
  input  logic                    valid,
  input  logic [REG_ADDR_LEN-1:0] dest,
  input  logic                    is_load,
  input  logic [REG_ADDR_LEN-1:0] src1,
  input  logic [REG_ADDR_LEN-1:0] src2,
  input  logic                    two_src,
  output logic                    match,
  output logic                    load_match
);

  logic hit1;
  logic hit2;

  // Register 0 is hardwired, so it can never carry a dependency.
  assign hit1       = valid && (dest == src1) && (src1 != '0);
  assign hit2       = valid && (dest == src2) && (src2 != '0) && two_src;
  assign match      = hit1 || hit2;
  assign load_match = match && is_load;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard tracking in-flight destinations (EXE..WB) and raising a stall request.
// Build option: FORWARDING_UNIT_EN restricts stalls to load-use hazards on the EXE entry.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned REG_ADDR_LEN = REG_ADDR_LEN_DEF,
  parameter int unsigned DEPTH        = DEPTH_DEF,
  parameter int unsigned CNT_LEN      = CNT_LEN_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REG_ADDR_LEN-1:0] src1,
  input  logic [REG_ADDR_LEN-1:0] src2,
  input  logic                    two_src,
  input  logic [REG_ADDR_LEN-1:0] id_dest,
  input  logic                    id_wb_en,
  input  logic                    id_mem_r_en,
  input  logic                    freeze,
  output logic                    hazard_detected,
  output logic [CNT_LEN-1:0]      stall_count,
  output logic [DEPTH-1:0]        sb_valid
);

  logic [DEPTH-1:0]                   ent_valid;
  logic [DEPTH-1:0][REG_ADDR_LEN-1:0] ent_dest;
  logic [DEPTH-1:0]                   ent_load;
  logic [DEPTH-1:0]                   match;
  logic [DEPTH-1:0]                   load_match;

  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    sb_match #(.REG_ADDR_LEN(REG_ADDR_LEN)) u_match (
      .valid      (ent_valid[g]),
      .dest       (ent_dest[g]),
      .is_load    (ent_load[g]),
      .src1       (src1),
      .src2       (src2),
      .two_src    (two_src),
      .match      (match[g]),
      .load_match (load_match[g])
    );
  end

  // load_match implies match, so folding both vectors in leaves the result unchanged.
`ifdef FORWARDING_UNIT_EN
  localparam logic [DEPTH-1:0] EXE_MASK = DEPTH'(1) << STAGE_EXE;
  assign hazard_detected = |(load_match & match & EXE_MASK);
`else
  assign hazard_detected = |(match | load_match);
`endif

  assign sb_valid = ent_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_valid <= '0;
      ent_dest  <= '0;
      ent_load  <= '0;
    end else if (!freeze) begin
      ent_valid[0] <= id_wb_en && (id_dest != '0);
      ent_dest[0]  <= id_dest;
      ent_load[0]  <= id_mem_r_en;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        ent_valid[i] <= ent_valid[i-1];
        ent_dest[i]  <= ent_dest[i-1];
        ent_load[i]  <= ent_load[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (hazard_detected && !freeze && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (plus a 2-bit counter copy for saturation).
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst;
  logic [4:0]  src1;
  logic [4:0]  src2;
  logic        two_src;
  logic [4:0]  id_dest;
  logic        id_wb_en;
  logic        id_mem_r_en;
  logic        freeze;
  logic        hazard_detected;
  logic [15:0] stall_count;
  logic [2:0]  sb_valid;
  logic        hazard_sat;
  logic [1:0]  count_sat;
  logic [2:0]  valid_sat;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .freeze(freeze), .hazard_detected(hazard_detected),
    .stall_count(stall_count), .sb_valid(sb_valid)
  );

  hazard_scoreboard #(.CNT_LEN(2)) u_sat (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .freeze(freeze), .hazard_detected(hazard_sat),
    .stall_count(count_sat), .sb_valid(valid_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_id(input logic [4:0] s1, input logic [4:0] s2, input logic two,
                        input logic [4:0] d, input logic wb, input logic mr);
    src1 = s1; src2 = s2; two_src = two; id_dest = d; id_wb_en = wb; id_mem_r_en = mr;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    freeze = 1'b0;
    set_id(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (hazard_detected !== 1'b0) begin
      errors++; $display("FAIL reset_hazard got %b want 0", hazard_detected);
    end
    checks++;
    if (stall_count !== 16'd0) begin
      errors++; $display("FAIL reset_count got %0d want 0", stall_count);
    end
    checks++;
    if (sb_valid !== 3'b000) begin
      errors++; $display("FAIL reset_valid got %b want 000", sb_valid);
    end
    step();
  endtask

  task automatic test_dependency();
    logic [2:0] exp_v [3];
    exp_v[0] = 3'b010; exp_v[1] = 3'b100; exp_v[2] = 3'b000;
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      set_id(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) step();
      set_id(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
      #1;
      checks++;
      if (hazard_detected !== 1'b0) begin
        errors++; $display("FAIL dep_producer_hazard rep %0d got %b want 0", rep, hazard_detected);
      end
      step();
      checks++;
      if (sb_valid !== 3'b001) begin
        errors++; $display("FAIL dep_valid_issue rep %0d got %b want 001", rep, sb_valid);
      end
      set_id(5'd3, 5'd5, 1'b1, 5'd4, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
        #1;
        checks++;
        if (hazard_detected !== 1'b1) begin
          errors++; $display("FAIL dep_stall rep %0d cyc %0d got %b want 1", rep, k, hazard_detected);
        end
        step();
        checks++;
        if (sb_valid !== exp_v[k]) begin
          errors++; $display("FAIL dep_valid rep %0d cyc %0d got %b want %b", rep, k, sb_valid, exp_v[k]);
        end
      end
      id_wb_en = 1'b1;
      #1;
      checks++;
      if (hazard_detected !== 1'b0) begin
        errors++; $display("FAIL dep_clear rep %0d got %b want 0", rep, hazard_detected);
      end
      step();
      checks++;
      if (sb_valid !== 3'b001) begin
        errors++; $display("FAIL dep_consumer_issue rep %0d got %b want 001", rep, sb_valid);
      end
      checks++;
      if (stall_count !== 16'(3 * (rep + 1))) begin
        errors++; $display("FAIL dep_count rep %0d got %0d want %0d", rep, stall_count, 3 * (rep + 1));
      end
    end
    checks++;
    if (count_sat !== 2'd3) begin
      errors++; $display("FAIL count_saturate got %0d want 3", count_sat);
    end
  endtask

  task automatic test_reg_zero();
    do_reset();
    set_id(5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);
    #1;
    step();
    checks++;
    if (sb_valid !== 3'b000) begin
      errors++; $display("FAIL r0_valid got %b want 000", sb_valid);
    end
    set_id(5'd0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0);
    #1;
    checks++;
    if (hazard_detected !== 1'b0) begin
      errors++; $display("FAIL r0_hazard got %b want 0", hazard_detected);
    end
    step();
    checks++;
    if (sb_valid !== 3'b001 || stall_count !== 16'd0) begin
      errors++; $display("FAIL r0_after got valid %b count %0d want 001 0", sb_valid, stall_count);
    end
  endtask

  task automatic test_two_src();
    do_reset();
    set_id(5'd3, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0);
    #1;
    checks++;
    if (hazard_detected !== 1'b0) begin
      errors++; $display("FAIL self_hazard got %b want 0", hazard_detected);
    end
    step();
    set_id(5'd1, 5'd3, 1'b0, 5'd4, 1'b1, 1'b0);
    #1;
    checks++;
    if (hazard_detected !== 1'b0) begin
      errors++; $display("FAIL src2_unused got %b want 0", hazard_detected);
    end
    two_src = 1'b1;
    #1;
    checks++;
`ifdef FORWARDING_UNIT_EN
    if (hazard_detected !== 1'b0) begin
      errors++; $display("FAIL src2_used got %b want 0", hazard_detected);
    end
`else
    if (hazard_detected !== 1'b1) begin
      errors++; $display("FAIL src2_used got %b want 1", hazard_detected);
    end
`endif
    step();
  endtask

`ifndef FORWARDING_UNIT_EN
  task automatic test_freeze();
    logic [2:0] exp_v [3];
    exp_v[0] = 3'b010; exp_v[1] = 3'b100; exp_v[2] = 3'b000;
    do_reset();
    set_id(5'd1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);
    step();
    set_id(5'd7, 5'd0, 1'b0, 5'd8, 1'b0, 1'b0);
    freeze = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (hazard_detected !== 1'b1) begin
        errors++; $display("FAIL frz_hazard cyc %0d got %b want 1", k, hazard_detected);
      end
      step();
      checks++;
      if (sb_valid !== 3'b001 || stall_count !== 16'd0) begin
        errors++; $display("FAIL frz_hold cyc %0d got valid %b count %0d want 001 0", k, sb_valid, stall_count);
      end
    end
    freeze = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (hazard_detected !== 1'b1) begin
        errors++; $display("FAIL frz_resume cyc %0d got %b want 1", k, hazard_detected);
      end
      step();
      checks++;
      if (sb_valid !== exp_v[k]) begin
        errors++; $display("FAIL frz_valid cyc %0d got %b want %b", k, sb_valid, exp_v[k]);
      end
    end
    #1;
    checks++;
    if (hazard_detected !== 1'b0 || stall_count !== 16'd3) begin
      errors++; $display("FAIL frz_end got hazard %b count %0d want 0 3", hazard_detected, stall_count);
    end
    step();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_id(5'd1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
    step();
    set_id(5'd9, 5'd0, 1'b0, 5'd10, 1'b0, 1'b0);
    #1;
    checks++;
    if (hazard_detected !== 1'b1) begin
      errors++; $display("FAIL mid_pre got %b want 1", hazard_detected);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (hazard_detected !== 1'b0 || sb_valid !== 3'b000) begin
      errors++; $display("FAIL mid_reset got hazard %b valid %b want 0 000", hazard_detected, sb_valid);
    end
    step();
    rst = 1'b1;
  endtask
`else
  task automatic test_forwarding();
    do_reset();
    set_id(5'd1, 5'd2, 1'b0, 5'd6, 1'b1, 1'b1);
    step();
    set_id(5'd6, 5'd0, 1'b0, 5'd7, 1'b0, 1'b0);
    #1;
    checks++;
    if (hazard_detected !== 1'b1) begin
      errors++; $display("FAIL fwd_load_use got %b want 1", hazard_detected);
    end
    step();
    id_wb_en = 1'b1;
    #1;
    checks++;
    if (hazard_detected !== 1'b0 || stall_count !== 16'd1) begin
      errors++; $display("FAIL fwd_load_clear got hazard %b count %0d want 0 1", hazard_detected, stall_count);
    end
    step();
    do_reset();
    set_id(5'd1, 5'd2, 1'b0, 5'd6, 1'b1, 1'b0);
    step();
    set_id(5'd6, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    #1;
    checks++;
    if (hazard_detected !== 1'b0) begin
      errors++; $display("FAIL fwd_alu_use got %b want 0", hazard_detected);
    end
    step();
    checks++;
    if (stall_count !== 16'd0) begin
      errors++; $display("FAIL fwd_alu_count got %0d want 0", stall_count);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifndef FORWARDING_UNIT_EN
    test_dependency();
`endif
    test_reg_zero();
    test_two_src();
`ifndef FORWARDING_UNIT_EN
    test_freeze();
    test_reset_mid_stall();
`else
    test_forwarding();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Hazard-detection stage directly upstream of the decode controller.
- Tracks destination registers of in-flight instructions in the EXE/MEM/WB stages.
- Drives hazard_detected into the controller; the controller then zeroes EXE_CMD, WB_EN and MEM_W_EN, which inserts a bubble.
- The controller's WB_EN/MEM_R_EN feed back into the scoreboard as the issued instruction's write intent. The scoreboard samples them only at the clock edge, so there is no combinational loop.

Parameters:
- REG_ADDR_LEN, 5: register-file address width.
- DEPTH, 3: tracked in-flight stages; entry 0 = EXE, entry DEPTH-1 = WB.
- CNT_LEN, 16: stall counter width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous active-low reset.
- src1  in  REG_ADDR_LEN  first source register of the instruction in ID.
- src2  in  REG_ADDR_LEN  second source register of the instruction in ID.
- two_src  in  1  src2 is actually read (R-type ALU ops, BNE).
- id_dest  in  REG_ADDR_LEN  destination register of the instruction in ID.
- id_wb_en  in  1  controller WB_EN (already 0 when a hazard is flagged).
- id_mem_r_en  in  1  controller MEM_R_EN.
- freeze  in  1  global pipeline freeze (memory wait); holds the scoreboard.
- hazard_detected  out  1  combinational stall request to the controller and IF/ID.
- stall_count  out  CNT_LEN  saturating count of hazard stall cycles.
- sb_valid  out  DEPTH  debug view of entry valid bits.

Behaviour:
- Entry i = {valid, dest[REG_ADDR_LEN-1:0], is_load}.
- Reset (rst=0, async): all entries invalid, dest=0, is_load=0; stall_count=0; hazard_detected=0; sb_valid=0.
- Match(i, s): entry[i].valid && entry[i].dest==s && s!=0.
- hazard_detected (combinational, same cycle as the inputs):
  - Asserted if any entry i has Match(i,src1) or (two_src && Match(i,src2)).
  - Register 0 never causes a hazard.
- Update at posedge clk when freeze=0:
  - entry[0] <= {id_wb_en && id_dest!=0, id_dest, id_mem_r_en}.
  - entry[i] <= entry[i-1] for i=1..DEPTH-1; entry[DEPTH-1] retires.
- Because id_wb_en is 0 during a hazard, a stalled cycle shifts in an invalid entry (bubble). The stall therefore self-clears once the producer leaves entry DEPTH-1.
- Stall latency without forwarding: a dependent instruction directly behind its producer stalls DEPTH cycles; a gap of k instructions stalls DEPTH-k cycles (minimum 0).
- freeze=1: entries hold; hazard_detected is still evaluated; stall_count holds.
- stall_count: +1 at posedge when hazard_detected=1 and freeze=0; saturates at all-ones with no wrap.
- Simultaneous case: id_dest equal to its own src (e.g. add r3,r3,r3) is not a self-hazard. Only older entries are compared.
- Reset mid-stall: the scoreboard clears immediately and hazard_detected drops in the same cycle.

Optional Feature:
- Macro: FORWARDING_UNIT_EN.
- Defined: EXE/MEM results are forwarded.
  - hazard_detected only for a load-use hazard: entry[0].valid && entry[0].is_load && (Match(0,src1) || two_src&&Match(0,src2)).
  - Maximum stall is 1 cycle.
- Undefined: full-interlock behaviour as above; is_load is stored but ignored.

Decomposition:
- REG_ADDR_LEN default, DEPTH default and the stage-index constants (STAGE_EXE=0, STAGE_MEM=1, STAGE_WB=2) go in defines.v, alongside the existing opcode and EXE_CMD defines.
- One natural sub-module: sb_match, a per-entry comparator taking entry, src1, src2 and two_src and returning match and load_match; instantiated DEPTH times.

Test Plan:
- Reset with rst=0, then release -> hazard_detected=0, stall_count=0, sb_valid=3'b000.
- Issue add r3,r1,r2 (wb_en=1,dest=3), then next cycle sub r4,r3,r5 (src1=3) -> without forwarding, hazard_detected=1 for exactly 3 cycles; stall_count=3; sb_valid sequence 001,010,100,000 with bubbles.
- Producer dest=0 with wb_en=1, then consumer src1=0 -> hazard_detected never asserts; sb_valid entry 0 stays 0.
- Dependency on src2 with two_src=0 (src2=3, dest=3 in flight) -> no hazard; same with two_src=1 -> hazard.
- Producer dest=7 in entry 0 and freeze=1 for 4 cycles -> hazard_detected stays 1; entries and stall_count unchanged; after freeze=0, stall resumes and clears after 3 unfrozen cycles.
- FORWARDING_UNIT_EN: load (mem_r_en=1,dest=6) then use src1=6 -> exactly 1 stall cycle. ALU producer dest=6 then use -> 0 stall cycles.
